// File: rtl/char_text_server_pkg.sv
// char_text_server_pkg: shared text-buffer geometry and clear FSM encoding.
package char_text_server_pkg;
    localparam int CHAR_COLS  = 32;
    localparam int CHAR_ROWS  = 16;
    localparam int FONT_LINES = 16;
    localparam int CODE_W     = 7;
    localparam int CELL_AW    = 9;
    typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_e;
endpackage

// File: rtl/char_text_server_font_rom.sv
// font_rom: 128 codes x 16 lines x 8-bit glyph ROM with registered output.
// Space is blank, 'A'/'B' are real glyphs, other codes show their code as a bar.
module font_rom (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] addr_i,
    output logic [7:0]  data_o
);
    logic [6:0] code;
    logic [3:0] line;
    logic [7:0] a_row, b_row, data_d, data_q;
    always_comb begin
        code = addr_i[10:4];
        line = addr_i[3:0];
        case (line)
            4'd2:                     a_row = 8'h10;
            4'd3:                     a_row = 8'h38;
            4'd4:                     a_row = 8'h6c;
            4'd7:                     a_row = 8'hfe;
            4'd5, 4'd6, 4'd8, 4'd9,
            4'd10, 4'd11:             a_row = 8'hc6;
            default:                  a_row = 8'h00;
        endcase
        case (line)
            4'd2, 4'd11:              b_row = 8'hfc;
            4'd6:                     b_row = 8'h7c;
            4'd3, 4'd4, 4'd5, 4'd7,
            4'd8, 4'd9, 4'd10:        b_row = 8'h66;
            default:                  b_row = 8'h00;
        endcase
        data_d = code == 7'h41 ? a_row :
                 code == 7'h42 ? b_row :
                 code == 7'h20 ? 8'h00 :
                 (line >= 4'd2 && line <= 4'd13) ? {1'b1, code} : 8'h00;
    end
    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end
    assign data_o = data_q;
endmodule

// File: rtl/char_text_server.sv
// char_text_server: 32x16 character buffer with 2-cycle glyph read path and bulk clear.
// Define CHAR_CURSOR_EN to compile in a blinking inverted cursor at cursor_addr.
module char_text_server
    import char_text_server_pkg::*;
#(
    parameter logic [CODE_W-1:0] FILL_CODE    = 7'h20,
    parameter int                BLINK_CYCLES = 20000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CELL_AW-1:0] char_xy,
    input  logic [3:0]         char_line,
    output logic [7:0]         char_pixels,
    input  logic               wr_en,
    input  logic [CELL_AW-1:0] wr_addr,
    input  logic [CODE_W-1:0]  wr_code,
    input  logic               clr_req,
    output logic               busy,
    output logic               clr_done,
    input  logic [CELL_AW-1:0] cursor_addr
);
    state_e              state_q, state_d;
    logic [CELL_AW-1:0]  cnt_q, cnt_d, wa;
    logic [CODE_W-1:0]   wd, code_q;
    logic [CODE_W-1:0]   mem_q [CHAR_COLS*CHAR_ROWS];
    logic [3:0]          line_q;
    logic                clearing, last, we, clr_done_q;
    logic [7:0]          font_pixels;
    always_comb begin
        clearing = state_q == CLEAR;
        last     = clearing && &cnt_q;
        state_d  = clearing ? (last ? IDLE : CLEAR) : (clr_req ? CLEAR : IDLE);
        cnt_d    = clearing ? cnt_q + 9'd1 : '0;
        we       = clearing | (wr_en & ~clr_req);
        wa       = clearing ? cnt_q : wr_addr;
        wd       = clearing ? FILL_CODE : wr_code;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
            code_q     <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_done_q <= last;
            code_q     <= mem_q[char_xy];
            line_q     <= char_line;
        end
    end
    // No reset on the array: reset restarts the clear, which rewrites every cell.
    always_ff @(posedge clk) begin
        if (we) mem_q[wa] <= wd;
    end
    assign busy     = clearing;
    assign clr_done = clr_done_q;
    font_rom u_font (
        .clk    (clk),
        .rst    (rst),
        .addr_i ({code_q, line_q}),
        .data_o (font_pixels)
    );
`ifdef CHAR_CURSOR_EN
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    logic [BW-1:0]      blink_cnt_q;
    logic [CELL_AW-1:0] xy_q;
    logic               phase_q, inv_q, wrap;
    assign wrap = blink_cnt_q == BLINK_LAST;
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            xy_q        <= '0;
            inv_q       <= 1'b0;
        end else begin
            blink_cnt_q <= wrap ? '0 : blink_cnt_q + BW'(1);
            phase_q     <= phase_q ^ wrap;
            xy_q        <= char_xy;
            inv_q       <= phase_q && xy_q == cursor_addr;
        end
    end
    assign char_pixels = font_pixels ^ {8{inv_q}};
`else
    logic unused_cursor;
    assign unused_cursor = ^{cursor_addr, BLINK_CYCLES[0]};
    assign char_pixels   = font_pixels;
`endif
endmodule
